instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the control unit.
- Holds the PC and runs an instruction-memory request/valid handshake.
- Latches the fetched word and splits it into OP_CODE/FUNCT_3/FUNCT_7 and register fields for decode.
- Computes the next PC from the PCS/BS selects produced downstream.

---
 rtl/instr_fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, runs the instruction-memory
// request/valid handshake, latches the fetched word and splits it into decode
// fields. It also selects the next PC from the downstream PCS/BS controls.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, a next PC with
// bit1 set raises a sticky TRAP and parks the unit in HALT. When it is not
// defined, the low two bits of the next PC are cleared and execution continues.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            IMEM_REQ,
    output logic [XLEN-1:0] IMEM_ADDR,
    input  logic            IMEM_VALID,
    input  logic [XLEN-1:0] IMEM_RDATA,
    input  logic            STALL,
    input  logic [1:0]      PCS,
    input  logic            BS,
    input  logic            ZERO,
    input  logic            NEG,
    input  logic [XLEN-1:0] BR_TARGET,
    input  logic [XLEN-1:0] JMP_TARGET,
    output logic [XLEN-1:0] INSTR,
    output logic [6:0]      OP_CODE,
    output logic [2:0]      FUNCT_3,
    output logic [6:0]      FUNCT_7,
    output logic [4:0]      RD,
    output logic [4:0]      RS1,
    output logic [4:0]      RS2,
    output logic            INSTR_VALID,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_PLUS4,
    output logic            TRAP
);

    localparam logic [XLEN-1:0] NOP       = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] FOUR      = XLEN'(4);
    localparam logic [XLEN-1:0] MASK_BIT0 = ~XLEN'(1);
    localparam logic [XLEN-1:0] MASK_LOW2 = ~XLEN'(3);

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
`ifdef MISALIGN_TRAP_EN
        StExec,
        StHalt
`else
        StExec
`endif
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            imem_req_q;
    logic            instr_valid_q;
    logic            trap_q;

    logic [XLEN-1:0] pc_plus4;
    logic            taken;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] next_pc_al;

    // Next-PC selection; jump target has bit0 cleared before anything else.
    always_comb begin
        pc_plus4 = pc_q + FOUR;
        taken    = BS ? !ZERO : !NEG;
        next_pc  = pc_plus4;
        unique case (PCS)
            2'b00:   next_pc = taken ? BR_TARGET : pc_plus4;
            2'b01:   next_pc = JMP_TARGET & MASK_BIT0;
            2'b10:   next_pc = pc_plus4;
            default: next_pc = pc_q;
        endcase
        next_pc_al = next_pc & MASK_LOW2;
    end

    // Fetch FSM with registered request/valid/trap outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC[XLEN-1:0];
            instr_q       <= NOP;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            case (state_q)
                StBoot: begin
                    state_q    <= StFetch;
                    imem_req_q <= 1'b1;
                end
                StFetch: begin
                    if (IMEM_VALID) begin
                        instr_q       <= IMEM_RDATA;
                        state_q       <= StExec;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                StExec: begin
                    if (!STALL) begin
`ifdef MISALIGN_TRAP_EN
                        if (next_pc[1]) begin
                            // PC stays on the offending instruction.
                            trap_q        <= 1'b1;
                            state_q       <= StHalt;
                            instr_valid_q <= 1'b0;
                            imem_req_q    <= 1'b0;
                        end else begin
                            pc_q          <= next_pc_al;
                            state_q       <= StFetch;
                            instr_valid_q <= 1'b0;
                            imem_req_q    <= 1'b1;
                        end
`else
                        pc_q          <= next_pc_al;
                        state_q       <= StFetch;
                        instr_valid_q <= 1'b0;
                        imem_req_q    <= 1'b1;
`endif
                    end
                end
`ifdef MISALIGN_TRAP_EN
                StHalt: begin
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
`endif
                default: begin
                    state_q       <= StBoot;
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Decode fields are plain slices of the latched word.
    always_comb begin
        INSTR       = instr_q;
        OP_CODE     = instr_q[6:0];
        RD          = instr_q[11:7];
        FUNCT_3     = instr_q[14:12];
        RS1         = instr_q[19:15];
        RS2         = instr_q[24:20];
        FUNCT_7     = instr_q[31:25];
        PC          = pc_q;
        PC_PLUS4    = pc_plus4;
        IMEM_ADDR   = pc_q;
        IMEM_REQ    = imem_req_q;
        INSTR_VALID = instr_valid_q;
`ifdef MISALIGN_TRAP_EN
        TRAP        = trap_q;
`else
        TRAP        = 1'b0;
`endif
    end

`ifndef MISALIGN_TRAP_EN
    // trap_q is only observable with the trap feature.
    logic unused_trap;
    assign unused_trap = trap_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. All expected values are hand-computed.
module tb_instr_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_VALID;
    logic [31:0] IMEM_RDATA;
    logic        STALL;
    logic [1:0]  PCS;
    logic        BS, ZERO, NEG;
    logic [31:0] BR_TARGET, JMP_TARGET;
    logic [31:0] INSTR;
    logic [6:0]  OP_CODE;
    logic [2:0]  FUNCT_3;
    logic [6:0]  FUNCT_7;
    logic [4:0]  RD, RS1, RS2;
    logic        INSTR_VALID;
    logic [31:0] PC, PC_PLUS4;
    logic        TRAP;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .CLK(CLK), .RST(RST), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_VALID(IMEM_VALID), .IMEM_RDATA(IMEM_RDATA), .STALL(STALL), .PCS(PCS),
        .BS(BS), .ZERO(ZERO), .NEG(NEG), .BR_TARGET(BR_TARGET), .JMP_TARGET(JMP_TARGET),
        .INSTR(INSTR), .OP_CODE(OP_CODE), .FUNCT_3(FUNCT_3), .FUNCT_7(FUNCT_7), .RD(RD),
        .RS1(RS1), .RS2(RS2), .INSTR_VALID(INSTR_VALID), .PC(PC), .PC_PLUS4(PC_PLUS4),
        .TRAP(TRAP)
    );

    always #5 CLK = ~CLK;

    // Advance one clock; sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Complete a zero-wait fetch (caller guarantees FETCH state).
    task automatic do_fetch(input logic [31:0] word);
        IMEM_VALID = 1'b1;
        IMEM_RDATA = word;
        tick();
        IMEM_VALID = 1'b0;
    endtask

    // One EXEC cycle with the given next-PC controls.
    task automatic do_exec(input logic [1:0] pcs, input logic bs, input logic zero,
                           input logic neg, input logic [31:0] br, input logic [31:0] jmp);
        PCS = pcs; BS = bs; ZERO = zero; NEG = neg; BR_TARGET = br; JMP_TARGET = jmp;
        STALL = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (IMEM_REQ !== 1'b0) begin
            errors++; $display("FAIL reset_req got %b exp 0", IMEM_REQ);
        end
        checks++;
        if (INSTR !== 32'h0000_0013) begin
            errors++; $display("FAIL reset_instr got %h exp 00000013", INSTR);
        end
        checks++;
        if (INSTR_VALID !== 1'b0) begin
            errors++; $display("FAIL reset_ivalid got %b exp 0", INSTR_VALID);
        end
        checks++;
        if (PC !== 32'h0) begin
            errors++; $display("FAIL reset_pc got %h exp 0", PC);
        end
        checks++;
        if (TRAP !== 1'b0) begin
            errors++; $display("FAIL reset_trap got %b exp 0", TRAP);
        end
        tick();
        checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h0) begin
            errors++; $display("FAIL boot_fetch got req %b addr %h exp 1 0", IMEM_REQ, IMEM_ADDR);
        end
    endtask

    task automatic test_basic();
        do_fetch(32'h0050_0093);
        checks++;
        if (INSTR_VALID !== 1'b1 || IMEM_REQ !== 1'b0) begin
            errors++; $display("FAIL basic_exec got iv %b req %b exp 1 0", INSTR_VALID, IMEM_REQ);
        end
        checks++;
        if (OP_CODE !== 7'b0010011 || RD !== 5'd1 || FUNCT_3 !== 3'd0) begin
            errors++; $display("FAIL basic_fields got op %h rd %0d f3 %0d exp 13 1 0",
                               OP_CODE, RD, FUNCT_3);
        end
        checks++;
        if (RS1 !== 5'd0 || RS2 !== 5'd5 || FUNCT_7 !== 7'd0) begin
            errors++; $display("FAIL basic_rs got rs1 %0d rs2 %0d f7 %0d exp 0 5 0", RS1, RS2, FUNCT_7);
        end
        checks++;
        if (PC_PLUS4 !== 32'h4) begin
            errors++; $display("FAIL basic_pcplus4 got %h exp 4", PC_PLUS4);
        end
        do_exec(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h4 || INSTR_VALID !== 1'b0) begin
            errors++; $display("FAIL basic_next got req %b addr %h iv %b exp 1 4 0",
                               IMEM_REQ, IMEM_ADDR, INSTR_VALID);
        end
        do_fetch(32'h0000_0013);
        do_exec(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_wait();
        // At PC=8: four request cycles before VALID.
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (IMEM_REQ !== 1'b1 || IMEM_ADDR !== 32'h8 || INSTR_VALID !== 1'b0) begin
                errors++; $display("FAIL wait_hold%0d got req %b addr %h iv %b exp 1 8 0",
                                   i, IMEM_REQ, IMEM_ADDR, INSTR_VALID);
            end
            if (i < 3) tick();
        end
        do_fetch(32'hABCD_E0B7);
        checks++;
        if (INSTR_VALID !== 1'b1 || INSTR !== 32'hABCD_E0B7) begin
            errors++; $display("FAIL wait_done got iv %b instr %h exp 1 abcde0b7", INSTR_VALID, INSTR);
        end
    endtask

    task automatic test_branch();
        // BNE taken (ZERO=0) from 8 to 0x40.
        do_exec(2'b00, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        checks++;
        if (IMEM_ADDR !== 32'h40) begin
            errors++; $display("FAIL bne_taken got %h exp 40", IMEM_ADDR);
        end
        do_fetch(32'h0000_0013);
        do_exec(2'b00, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0);
        checks++;
        if (IMEM_ADDR !== 32'h44) begin
            errors++; $display("FAIL bne_not got %h exp 44", IMEM_ADDR);
        end
        do_fetch(32'h0000_0013);
        do_exec(2'b00, 1'b0, 1'b0, 1'b1, 32'h80, 32'h0);
        checks++;
        if (IMEM_ADDR !== 32'h48) begin
            errors++; $display("FAIL bge_not got %h exp 48", IMEM_ADDR);
        end
        do_fetch(32'h0000_0013);
        do_exec(2'b00, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0);
        checks++;
        if (IMEM_ADDR !== 32'h80) begin
            errors++; $display("FAIL bge_taken got %h exp 80", IMEM_ADDR);
        end
    endtask

    task automatic test_stall();
        do_fetch(32'h1234_5678);
        PCS = 2'b10;
        STALL = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (INSTR !== 32'h1234_5678 || PC !== 32'h80 || INSTR_VALID !== 1'b1 ||
                IMEM_REQ !== 1'b0) begin
                errors++; $display("FAIL stall%0d got instr %h pc %h iv %b req %b exp 12345678 80 1 0",
                                   i, INSTR, PC, INSTR_VALID, IMEM_REQ);
            end
        end
        do_exec(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (IMEM_ADDR !== 32'h84 || IMEM_REQ !== 1'b1) begin
            errors++; $display("FAIL stall_release got addr %h req %b exp 84 1", IMEM_ADDR, IMEM_REQ);
        end
    endtask

    task automatic test_jump_wrap();
        do_fetch(32'h0000_006F);
        do_exec(2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0105);
        checks++;
        if (IMEM_ADDR !== 32'h104) begin
            errors++; $display("FAIL jump_odd got %h exp 104", IMEM_ADDR);
        end
        do_fetch(32'h0000_006F);
        do_exec(2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFC);
        checks++;
        if (IMEM_ADDR !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL jump_top got %h exp fffffffc", IMEM_ADDR);
        end
        do_fetch(32'h0000_0013);
        checks++;
        if (PC_PLUS4 !== 32'h0) begin
            errors++; $display("FAIL wrap_plus4 got %h exp 0", PC_PLUS4);
        end
        do_exec(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (IMEM_ADDR !== 32'h0) begin
            errors++; $display("FAIL wrap_next got %h exp 0", IMEM_ADDR);
        end
        // PCS=11 refetches the same address.
        do_fetch(32'h0000_0013);
        do_exec(2'b11, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (IMEM_ADDR !== 32'h0 || IMEM_REQ !== 1'b1) begin
            errors++; $display("FAIL hold_pc got addr %h req %b exp 0 1", IMEM_ADDR, IMEM_REQ);
        end
        do_exec(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset_midfetch();
        // Move PC away from reset value first.
        do_fetch(32'h0000_0013);
        do_exec(2'b10, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        IMEM_VALID = 1'b1;
        IMEM_RDATA = 32'hFFFF_FFFF;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        IMEM_VALID = 1'b0;
        checks++;
        if (INSTR !== 32'h13 || PC !== 32'h0 || IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0) begin
            errors++; $display("FAIL midfetch_rst got instr %h pc %h req %b iv %b exp 13 0 0 0",
                               INSTR, PC, IMEM_REQ, INSTR_VALID);
        end
        tick();
    endtask

    task automatic test_misalign();
        do_fetch(32'h0000_006F);
        do_exec(2'b01, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0102);
`ifdef MISALIGN_TRAP_EN
        checks++;
        if (TRAP !== 1'b1 || IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0 || PC !== 32'h0) begin
            errors++; $display("FAIL trap_set got trap %b req %b iv %b pc %h exp 1 0 0 0",
                               TRAP, IMEM_REQ, INSTR_VALID, PC);
        end
        IMEM_VALID = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        IMEM_VALID = 1'b0;
        checks++;
        if (TRAP !== 1'b1 || IMEM_REQ !== 1'b0 || INSTR_VALID !== 1'b0) begin
            errors++; $display("FAIL trap_halt got trap %b req %b iv %b exp 1 0 0",
                               TRAP, IMEM_REQ, INSTR_VALID);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (TRAP !== 1'b0) begin
            errors++; $display("FAIL trap_clear got %b exp 0", TRAP);
        end
`else
        checks++;
        if (TRAP !== 1'b0 || IMEM_ADDR !== 32'h100 || IMEM_REQ !== 1'b1) begin
            errors++; $display("FAIL misalign_force got trap %b addr %h req %b exp 0 100 1",
                               TRAP, IMEM_ADDR, IMEM_REQ);
        end
        // Misaligned branch target also gets bits [1:0] cleared.
        do_fetch(32'h0000_0063);
        do_exec(2'b00, 1'b1, 1'b0, 1'b0, 32'h0000_004E, 32'h0);
        checks++;
        if (IMEM_ADDR !== 32'h4C || TRAP !== 1'b0) begin
            errors++; $display("FAIL misalign_br got addr %h trap %b exp 4c 0", IMEM_ADDR, TRAP);
        end
`endif
    endtask

    initial begin
        RST = 1'b0; IMEM_VALID = 1'b0; IMEM_RDATA = 32'h0; STALL = 1'b0;
        PCS = 2'b10; BS = 1'b0; ZERO = 1'b0; NEG = 1'b0;
        BR_TARGET = 32'h0; JMP_TARGET = 32'h0;
        test_reset();
        test_basic();
        test_wait();
        test_branch();
        test_stall();
        test_jump_wrap();
        test_reset_midfetch();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
